// File: rtl/fetch_queue_if.sv
// Bus bundle for fetch_queue: decode redirect, instruction-memory request and
// response channels, and the instruction output towards the IF/ID register.
interface fetch_queue_if;
  // Handshakes: a request transfers on a rising edge where imem_req=1 and imem_gnt=1;
  // responses carry no back-pressure and arrive in request order; an output
  // instruction transfers on a rising edge where out_valid=1 and out_ready=1;
  // redirect=1 overrides every other transfer in its cycle.
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc_incr;
  logic        out_ready;

  modport master (
    input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_instr, out_pc_incr
  );

  modport slave (
    output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_instr, out_pc_incr
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-limited request issue, in-order response FIFO,
// redirect flush with discard of stale responses. FETCHQ_BYPASS_EN adds an empty-queue bypass.
module fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                             clk,
  input  logic                             rst,
  fetch_queue_if.master                    bus,
  output logic [1:0]                       dbg_state,
  output logic [$clog2(DEPTH+1)-1:0]       dbg_count,
  output logic [$clog2(MAX_OUTST+1)-1:0]   dbg_outst
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] count;
  logic [OW-1:0] outst;
  logic [OW-1:0] discard;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];

  logic          req;
  logic          req_acc;
  logic          resp_keep;
  logic          bypass;
  logic          push;
  logic          pop;
  logic [OW-1:0] outst_after;

  always_comb begin
    req         = 1'b0;
    req_acc     = 1'b0;
    resp_keep   = 1'b0;
    bypass      = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    outst_after = outst - OW'(bus.imem_rvalid);
    // Credit rule: in-flight requests reserve FIFO space so a response always fits.
    req = (state == RUN) && !bus.redirect && (32'(outst) < MAX_OUTST) &&
          (32'(count) + 32'(outst) < DEPTH);
    req_acc   = req && bus.imem_gnt;
    resp_keep = bus.imem_rvalid && (discard == '0) && !bus.redirect;
`ifdef FETCHQ_BYPASS_EN
    bypass = resp_keep && (count == '0);
`else
    bypass = 1'b0;
`endif
    pop  = (count != '0) && bus.out_ready && !bus.redirect;
    push = resp_keep && !(bypass && bus.out_ready);
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_pc;
  assign bus.out_valid   = (count != '0) || bypass;
  assign bus.out_instr   = bypass ? bus.imem_rdata : mem_instr[rd_ptr];
  assign bus.out_pc_incr = bypass ? (resp_pc + 32'd4) : mem_pc[rd_ptr];

  assign dbg_state = state;
  assign dbg_count = count;
  assign dbg_outst = outst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      count    <= '0;
      outst    <= '0;
      discard  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_instr[PW'(i)] <= '0;
        mem_pc[PW'(i)]    <= '0;
      end
    end else begin
      outst <= outst_after + OW'(req_acc);
      if (bus.redirect) begin
        // Everything still in flight after this cycle belongs to the old path.
        fetch_pc <= bus.redirect_pc;
        resp_pc  <= bus.redirect_pc;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        discard  <= outst_after;
        state    <= (outst_after != '0) ? FLUSH : RUN;
      end else begin
        if (req_acc)
          fetch_pc <= fetch_pc + 32'd4;
        if (bus.imem_rvalid && (discard != '0))
          discard <= discard - OW'(1);
        if (resp_keep)
          resp_pc <= resp_pc + 32'd4;
        if (push) begin
          mem_instr[wr_ptr] <= bus.imem_rdata;
          mem_pc[wr_ptr]    <= resp_pc + 32'd4;
          wr_ptr            <= wr_ptr + PW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
        case (state)
          IDLE:    state <= RUN;
          FLUSH:   if (bus.imem_rvalid && (discard == OW'(1))) state <= RUN;
          default: state <= state;
        endcase
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count == CW'(DEPTH))));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: memory responder with programmable latency,
// scoreboard of expected {instr, pc+4} entries checked by an output monitor.
module tb_fetch_queue;
  localparam int W = 64;

  logic        clk;
  logic        rst;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_count;
  logic [1:0]  dbg_outst;

  fetch_queue_if bus();

  fetch_queue dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count),
    .dbg_outst (dbg_outst)
  );

  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] limit = 32'h0;
  logic [31:0] next_addr = 32'h0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h2002_0025;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = start + 32'(4 * i);
      exp_q.push_back({instr_of(a), a + 32'd4});
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // memory responder: grants below limit, answers in order after lat cycles
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
      bus.imem_rvalid = 1'b0;
      bus.imem_gnt    = 1'b0;
    end else begin
      if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = instr_of(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        bus.imem_rvalid = 1'b0;
      end
      bus.imem_gnt = (bus.imem_addr < limit);
    end
  end

  // monitor: request addresses and output transfers, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.imem_req && bus.imem_gnt) begin
        pend_addr.push_back(bus.imem_addr);
        pend_due.push_back(cyc + lat);
        check("req_addr", bus.imem_addr, next_addr);
        next_addr = next_addr + 32'd4;
      end
      if (bus.out_valid && bus.out_ready && !bus.redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%h/%h expected=none", bus.out_instr, bus.out_pc_incr);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("out_instr", bus.out_instr, e[63:32]);
          check("out_pc_incr", bus.out_pc_incr, e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  hit;
    rst             = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready   = 1'b1;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;

    // reset state
    step();
    step();
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_out_pc_incr", bus.out_pc_incr, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_count", 32'(dbg_count), 32'd0);

    // streaming: addresses 0..3C, pc+4 4..40
    lat   = 1;
    limit = 32'h40;
    push_exp(32'h0, 16);
    rst = 1'b0;
    step();
    check("idle_to_run", 32'(dbg_state), 32'd1);
    drain("drain_stream");

    // redirect to 0x100 with two requests in flight
    lat   = 3;
    limit = 32'h120;
    n = 0;
    while (dbg_outst != 2'd2 && n < 20) begin
      step();
      n++;
    end
    check("outst_before_redirect", 32'(dbg_outst), 32'd2);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    next_addr       = 32'h100;
    push_exp(32'h100, 8);
    step();
    bus.redirect = 1'b0;
    #1;
    check("flush_state", 32'(dbg_state), 32'd2);
    check("flush_no_req", 32'(bus.imem_req), 32'd0);
    drain("drain_redirect");
    check("run_after_flush", 32'(dbg_state), 32'd1);

    // back-pressure: 12 cycles of out_ready=0
    lat           = 1;
    limit         = 32'h160;
    bus.out_ready = 1'b0;
    push_exp(32'h120, 16);
    repeat (12) step();
    check("sat_count", 32'(dbg_count), 32'd4);
    check("sat_outst", 32'(dbg_outst), 32'd0);
    check("sat_no_req", 32'(bus.imem_req), 32'd0);
    bus.out_ready = 1'b1;
    drain("drain_backpressure");

    // redirect in a cycle with both a push and a pop
    limit         = 32'h320;
    bus.out_ready = 1'b0;
    push_exp(32'h160, 40);
    repeat (3) step();
    bus.out_ready = 1'b1;
    #1;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (dbg_count != 3'd0 && bus.imem_rvalid && dbg_state == 2'd1)
        hit = 1'b1;
      else
        step();
    end
    check("push_pop_cycle_found", 32'(hit), 32'd1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h300;
    next_addr       = 32'h300;
    exp_q.delete();
    push_exp(32'h300, 8);
    step();
    bus.redirect = 1'b0;
    #1;
    check("redir_count", 32'(dbg_count), 32'd0);
    check("redir_out_valid", 32'(bus.out_valid), 32'd0);
    check("redir_req", 32'(bus.imem_req), 32'd1);
    check("redir_addr", bus.imem_addr, 32'h300);
    drain("drain_redirect2");

    // reset mid-stream with three entries queued
    limit         = 32'h360;
    bus.out_ready = 1'b0;
    n = 0;
    while (dbg_count != 3'd3 && n < 20) begin
      step();
      n++;
    end
    check("count_before_reset", 32'(dbg_count), 32'd3);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_req", 32'(bus.imem_req), 32'd0);
    check("mid_rst_out_instr", bus.out_instr, 32'd0);
    check("mid_rst_count", 32'(dbg_count), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    exp_q.delete();
    next_addr     = 32'h0;
    limit         = 32'h20;
    bus.out_ready = 1'b1;
    push_exp(32'h0, 8);
    step();
    step();
    rst = 1'b0;
    drain("drain_after_reset");

    // response-to-out_valid latency on an empty queue
    push_exp(32'h20, 1);
    limit = 32'h24;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      step();
      if (bus.imem_rvalid) hit = 1'b1;
    end
    check("resp_seen", 32'(hit), 32'd1);
    check("resp_rdata", bus.imem_rdata, 32'h2002_0005);
`ifdef FETCHQ_BYPASS_EN
    check("bypass_valid_same", 32'(bus.out_valid), 32'd1);
    check("bypass_instr_same", bus.out_instr, 32'h2002_0005);
    step();
    check("bypass_valid_next", 32'(bus.out_valid), 32'd0);
`else
    check("nobypass_valid_same", 32'(bus.out_valid), 32'd0);
    step();
    check("nobypass_valid_next", 32'(bus.out_valid), 32'd1);
    check("nobypass_instr_next", bus.out_instr, 32'h2002_0005);
    check("nobypass_pc_next", bus.out_pc_incr, 32'h24);
`endif
    drain("drain_latency");
    repeat (3) step();
    check("final_outst", 32'(dbg_outst), 32'd0);
    check("final_count", 32'(dbg_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
